// File: rtl/ssd1306_command_decoder.sv
// SSD1306-compatible command/data decoder: interprets the SPI byte stream, keeps display
// settings and the GDDRAM write pointer, and emits one bitmap RAM write per data byte.
module ssd1306_command_decoder #(
  parameter int PAGES = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       DC_i,
  input  logic [7:0] Data_i,
  input  logic       DataValid_i,
  output logic       WriteEnable_o,
  output logic [9:0] WriteAddress_o,
  output logic [7:0] WriteData_o,
  output logic       DisplayOn_o,
  output logic       Inverse_o,
  output logic [7:0] Contrast_o
);

  typedef enum logic [2:0] {
    CMD,
    ARG_CONTRAST,
    ARG_MODE,
    ARG_COL_START,
    ARG_COL_END,
    ARG_PAGE_START,
    ARG_PAGE_END
  } state_e;

  localparam logic [1:0] MODE_HORIZ = 2'b00;
  localparam logic [1:0] MODE_VERT  = 2'b01;
  localparam logic [1:0] MODE_PAGE  = 2'b10;
  localparam logic [2:0] LAST_PAGE  = 3'(PAGES - 1);
  localparam logic [6:0] LAST_COL   = 7'd127;

  state_e     state_q, state_d;
  logic       we_q, we_d;
  logic [9:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       disp_q, disp_d;
  logic       inv_q, inv_d;
  logic [7:0] contrast_q, contrast_d;
  logic [1:0] mode_q, mode_d;
  logic [6:0] col_q, col_d;
  logic [2:0] page_q, page_d;
  logic [6:0] col_start_q, col_start_d;
  logic [6:0] col_end_q, col_end_d;
  logic [2:0] page_start_q, page_start_d;
  logic [2:0] page_end_q, page_end_d;

  logic       col_at_end;
  logic       page_at_end;
  logic [6:0] col_adv;
  logic [2:0] page_adv;

  // A range end past the physical edge never matches, so the physical edge also wraps.
  always_comb begin
    col_at_end  = (col_q == col_end_q) || (col_q == LAST_COL);
    page_at_end = (page_q == page_end_q) || (page_q == LAST_PAGE);
    col_adv     = col_at_end ? col_start_q : col_q + 7'd1;
    page_adv    = page_at_end ? page_start_q : page_q + 3'd1;
  end

  always_comb begin
    state_d      = state_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    disp_d       = disp_q;
    inv_d        = inv_q;
    contrast_d   = contrast_q;
    mode_d       = mode_q;
    col_d        = col_q;
    page_d       = page_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;

    if (DataValid_i) begin
      if (DC_i) begin
        // Data always wins: any half-received command is dropped.
        state_d = CMD;
        we_d    = 1'b1;
        addr_d  = {page_q, col_q};
        wdata_d = Data_i;
        case (mode_q)
          MODE_HORIZ: begin
            col_d = col_adv;
            if (col_at_end) page_d = page_adv;
          end
          MODE_VERT: begin
            page_d = page_adv;
            if (page_at_end) col_d = col_adv;
          end
          default: col_d = col_q + 7'd1;
        endcase
      end else begin
        case (state_q)
          CMD: begin
            case (Data_i)
              8'hAE: disp_d = 1'b0;
              8'hAF: disp_d = 1'b1;
              8'hA6: inv_d = 1'b0;
              8'hA7: inv_d = 1'b1;
              8'h81: state_d = ARG_CONTRAST;
              8'h20: state_d = ARG_MODE;
              8'h21: state_d = ARG_COL_START;
              8'h22: state_d = ARG_PAGE_START;
              default: begin
                if (mode_q == MODE_PAGE) begin
                  if (Data_i[7:4] == 4'h0) begin
                    col_d[3:0] = Data_i[3:0];
                  end else if (Data_i[7:3] == 5'b00010) begin
                    col_d[6:4] = Data_i[2:0];
                  end else if (Data_i[7:3] == 5'b10110) begin
                    page_d = Data_i[2:0];
                  end
                end
              end
            endcase
          end
          ARG_CONTRAST: begin
            contrast_d = Data_i;
            state_d    = CMD;
          end
          ARG_MODE: begin
            if (Data_i[1:0] != 2'b11) mode_d = Data_i[1:0];
            state_d = CMD;
          end
          ARG_COL_START: begin
            col_start_d = Data_i[6:0];
            state_d     = ARG_COL_END;
          end
          ARG_COL_END: begin
            col_end_d = Data_i[6:0];
            col_d     = col_start_q;
            state_d   = CMD;
          end
          ARG_PAGE_START: begin
            page_start_d = Data_i[2:0];
            state_d      = ARG_PAGE_END;
          end
          ARG_PAGE_END: begin
            page_end_d = Data_i[2:0];
            page_d     = page_start_q;
            state_d    = CMD;
          end
          default: state_d = CMD;
        endcase
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= CMD;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      disp_q       <= 1'b0;
      inv_q        <= 1'b0;
      contrast_q   <= 8'h7F;
      mode_q       <= MODE_PAGE;
      col_q        <= '0;
      page_q       <= '0;
      col_start_q  <= '0;
      col_end_q    <= LAST_COL;
      page_start_q <= '0;
      page_end_q   <= LAST_PAGE;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      disp_q       <= disp_d;
      inv_q        <= inv_d;
      contrast_q   <= contrast_d;
      mode_q       <= mode_d;
      col_q        <= col_d;
      page_q       <= page_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
    end
  end

  assign WriteEnable_o  = we_q;
  assign WriteAddress_o = addr_q;
  assign WriteData_o    = wdata_q;
  assign DisplayOn_o    = disp_q;
  assign Inverse_o      = inv_q;
  assign Contrast_o     = contrast_q;

endmodule

// File: doc/ssd1306_command_decoder.md
SSD1306_COMMAND_DECODER -- requirements
Module: ssd1306_command_decoder

Interface
REQ-001 SHALL have parameter: PAGES, 8, number of 8-row pages (8 = 128x64, 4 = 128x32).
REQ-002 SHALL have port: Clock  input  1  single clock for all logic.
REQ-003 SHALL have port: Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: DC_i  input  1  already-synchronized data/command flag; 1 = data, 0 = command.
REQ-005 SHALL have port: Data_i  input  8  byte received from the SPI slave.
REQ-006 SHALL have port: DataValid_i  input  1  one-cycle strobe; Data_i and DC_i are valid in this cycle.
REQ-007 SHALL have port: WriteEnable_o  output  1  one-cycle write strobe to the bitmap RAM.
REQ-008 SHALL have port: WriteAddress_o  output  10  RAM address, {page[2:0], column[6:0]}.
REQ-009 SHALL have port: WriteData_o  output  8  byte to write.
REQ-010 SHALL have port: DisplayOn_o  output  1  display enable (0xAE/0xAF).
REQ-011 SHALL have port: Inverse_o  output  1  inverse video (0xA6/0xA7).
REQ-012 SHALL have port: Contrast_o  output  8  contrast register (0x81).

Function
REQ-013 SHALL process a byte only in a cycle with DataValid_i=1; all other cycles SHALL leave state unchanged and drive WriteEnable_o=0.
REQ-014 SHALL, for a data byte (DC_i=1), drive WriteEnable_o=1 exactly one cycle later, with WriteData_o=Data_i and WriteAddress_o={page,col} from before the pointer update.
REQ-015 SHALL use an FSM with states CMD, ARG_CONTRAST, ARG_MODE, ARG_COL_START, ARG_COL_END, ARG_PAGE_START, ARG_PAGE_END; reset state is CMD.
REQ-016 SHALL decode command opcodes in CMD as follows: 0xAE/0xAF set DisplayOn_o 0/1; 0xA6/0xA7 set Inverse_o 0/1; 0x81 goes to ARG_CONTRAST; 0x20 goes to ARG_MODE; 0x21 goes to ARG_COL_START; 0x22 goes to ARG_PAGE_START.
REQ-017 SHALL, in page mode only, decode 0x00-0x0F as col[3:0]=Data_i[3:0], 0x10-0x17 as col[6:4]=Data_i[2:0], and 0xB0-0xB7 as page=Data_i[2:0]; in other modes these opcodes SHALL be ignored.
REQ-018 SHALL ignore all other opcodes, remaining in CMD.
REQ-019 SHALL handle argument bytes with DC_i=0 as follows: ARG_CONTRAST loads Contrast_o; ARG_MODE loads mode=Data_i[1:0] (00 horizontal, 01 vertical, 10 page, 11 ignored); each then returns to CMD.
REQ-020 SHALL handle ARG_COL_START/ARG_COL_END by loading col_start/col_end=Data_i[6:0]; after the end byte, col SHALL equal col_start and the FSM SHALL return to CMD.
REQ-021 SHALL handle ARG_PAGE_START/ARG_PAGE_END by loading page_start/page_end=Data_i[2:0]; after the end byte, page SHALL equal page_start and the FSM SHALL return to CMD.
REQ-022 SHALL, on a data byte received in any ARG_* state, abandon the pending command, return to CMD, and write the data byte normally.
REQ-023 SHALL advance the pointer in horizontal mode as: col wraps when col==col_end or col==127; on wrap col=col_start and page advances, with page wrapping to page_start when page==page_end or page==PAGES-1; otherwise col+1.
REQ-024 SHALL advance the pointer in vertical mode as: page wraps under the same condition as REQ-023; on page wrap page=page_start and col advances with the REQ-023 column wrap rule; otherwise page+1.
REQ-025 SHALL advance the pointer in page mode as: col+1, with col wrapping from 127 to 0; page never changes.
REQ-026 SHALL apply start>end ranges with the same rules, so the pointer runs to 127 or PAGES-1 and then wraps to start.

Reset
REQ-027 SHALL, on Reset=1 at any time (including mid-command), asynchronously set: state=CMD, WriteEnable_o=0, WriteAddress_o=0, WriteData_o=0, DisplayOn_o=0, Inverse_o=0, Contrast_o=0x7F, mode=page, col=0, page=0, col_start=0, col_end=127, page_start=0, page_end=PAGES-1.

Verification
REQ-028 SHALL verify: after reset, command 0xAF, then data 0x55 -> DisplayOn_o=1; one cycle after the data strobe WriteEnable_o=1, WriteAddress_o=0, WriteData_o=0x55.
REQ-029 SHALL verify: commands 0x20,0x00,0x21,0x7E,0x7F,0x22,0x06,0x07, then 5 data bytes -> addresses 0x37E, 0x37F, 0x3FE, 0x3FF, 0x37E.
REQ-030 SHALL verify: page mode, commands 0xB3,0x0F,0x17, then 2 data bytes -> addresses 0x1FF, 0x180.
REQ-031 SHALL verify: command 0x81 followed by data 0xAA (DC_i=1) -> Contrast_o unchanged at 0x7F; write of 0xAA occurs; FSM is in CMD.
REQ-032 SHALL verify: vertical mode (0x20,0x01), PAGES=8, 9 data bytes -> addresses 0x000, 0x080, ..., 0x380, 0x001.
REQ-033 SHALL verify: Reset asserted between 0x21 and its first argument -> all REQ-027 values; a following byte 0x05 with DC_i=0 is treated as an opcode (page mode: col[3:0]=5).
